// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: one-deep skid buffer, redirect flush and in-flight request discard.
// Defining FETCH_PERF_EN adds fetch_cnt/bubble_cnt performance counter outputs.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic [31:0] ifid_instr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [31:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_skid_instr, w_skid_instr_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        w_adv;

  assign pc_out     = r_pc;
  assign imem_addr  = r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_instr = r_ifid_instr;
  assign w_adv      = ~stall | ~r_ifid_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;
    w_target_nxt     = r_target;
    imem_req         = 1'b0;
    // IF/ID holds under stall, otherwise becomes a bubble unless loaded below
    w_ifid_valid_nxt = stall ? r_ifid_valid : 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect) begin
          w_pc_nxt         = redirect_target;
          w_ifid_valid_nxt = 1'b0;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          w_ifid_valid_nxt = 1'b0;
          if (imem_ack) begin
            w_pc_nxt = redirect_target;
          end else begin
            w_target_nxt = redirect_target;
            w_state_nxt  = S_DISCARD;
          end
        end else if (imem_ack) begin
          w_pc_nxt = npc_in;
          if (w_adv) begin
            w_ifid_pc_nxt    = r_pc;
            w_ifid_instr_nxt = imem_rdata;
            w_ifid_valid_nxt = 1'b1;
          end else begin
            w_skid_pc_nxt    = r_pc;
            w_skid_instr_nxt = imem_rdata;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt         = redirect_target;
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
        end else if (!stall) begin
          w_ifid_pc_nxt    = r_skid_pc;
          w_ifid_instr_nxt = r_skid_instr;
          w_ifid_valid_nxt = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end
      S_DISCARD: begin
        // The abandoned fetch must still complete; the newest redirect target wins
        imem_req = 1'b1;
        if (redirect) w_target_nxt = redirect_target;
        if (imem_ack) begin
          w_pc_nxt    = redirect ? redirect_target : r_target;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc         <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 32'd0;
      r_ifid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_target     <= 32'd0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_target     <= w_target_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;
  logic        w_load;

  // A live IF/ID after the edge is a fresh load unless it was simply held by stall
  assign w_load     = w_ifid_valid_nxt & ~(stall & r_ifid_valid);
  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      r_fetch_cnt  <= r_fetch_cnt + {31'd0, w_load};
      r_bubble_cnt <= r_bubble_cnt + {31'd0, ~w_ifid_valid_nxt};
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level reference model. Counter checks are included when FETCH_PERF_EN is defined.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] npc_in = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc_out;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .npc_in(npc_in), .redirect(redirect),
    .redirect_target(redirect_target), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
    .ifid_instr(ifid_instr)
  );

  always #5 clk = ~clk;

  // Reference model: the fetch unit seen as "what is in flight, what is buffered, what is in IF/ID"
  logic [31:0] m_pc, m_ipc, m_instr, m_spc, m_sinstr, m_tgt, m_fetch, m_bubble;
  bit          m_vld, m_started, m_hold, m_discard;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_ipc = 0; m_instr = 0; m_spc = 0; m_sinstr = 0; m_tgt = 0;
    m_fetch = 0; m_bubble = 0; m_vld = 0; m_started = 0; m_hold = 0; m_discard = 0;
  endtask

  task automatic model_step(input bit rd, input logic [31:0] tgt, input bit st, input bit ak);
    if (!m_started) begin
      m_started = 1;
      if (rd) begin m_pc = tgt; m_vld = 0; end
    end else if (m_hold) begin
      if (rd) begin m_hold = 0; m_pc = tgt; m_vld = 0; end
      else if (!st) begin m_hold = 0; m_ipc = m_spc; m_instr = m_sinstr; m_vld = 1; m_fetch++; end
    end else if (m_discard) begin
      if (rd) m_tgt = tgt;
      if (ak) begin m_discard = 0; m_pc = m_tgt; end
    end else begin
      if (rd) begin
        m_vld = 0;
        if (ak) m_pc = tgt;
        else begin m_tgt = tgt; m_discard = 1; end
      end else if (ak) begin
        if (!st || !m_vld) begin m_ipc = m_pc; m_instr = mem(m_pc); m_vld = 1; m_fetch++; end
        else begin m_spc = m_pc; m_sinstr = mem(m_pc); m_hold = 1; end
        m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_vld = 0;
      end
    end
    if (!m_vld) m_bubble++;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, land on the next falling edge
  task automatic step(input bit rd, input logic [31:0] tgt, input bit st, input bit ak);
    redirect = rd; redirect_target = tgt; stall = st; imem_ack = ak;
    imem_rdata = mem(imem_addr);
    npc_in = pc_out + 32'd4;
    model_step(rd, tgt, st, ak);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; redirect = 0; redirect_target = 0; stall = 0; imem_ack = 0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc_out, RST_PC); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ifid_valid); end
    checks++; if ({ifid_pc, ifid_instr} !== 64'd0) begin errors++; $display("FAIL reset_ifid got=%h want=0", {ifid_pc, ifid_instr}); end
    do_reset();
    step(0, 0, 0, 1);
    checks++; if ({imem_req, ifid_valid} !== 2'b10) begin errors++; $display("FAIL idle_to_req got=%b want=10", {imem_req, ifid_valid}); end
  endtask

  task automatic test_streaming();
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1);
      checks++;
      if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'(i * 4), mem(32'(i * 4))}) begin
        errors++; $display("FAIL stream_%0d got=%b/%h/%h want=1/%h/%h", i, ifid_valid, ifid_pc, ifid_instr, 32'(i * 4), mem(32'(i * 4)));
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL skid_setup_pc got=%h want=10", pc_out); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      checks++;
      if ({imem_req, ifid_valid, ifid_pc, imem_addr} !== {2'b01, 32'hC, 32'h14}) begin
        errors++; $display("FAIL skid_hold_%0d got=%b%b/%h/%h want=01/0000000c/00000014", i, imem_req, ifid_valid, ifid_pc, imem_addr);
      end
    end
    step(0, 0, 0, 1);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr, imem_req} !== {1'b1, 32'h10, mem(32'h10), 1'b1}) begin
      errors++; $display("FAIL skid_release got=%b/%h/%h/%b want=1/00000010/%h/1", ifid_valid, ifid_pc, ifid_instr, imem_req, mem(32'h10));
    end
    step(0, 0, 0, 1);
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h14}) begin errors++; $display("FAIL skid_next got=%b/%h want=1/00000014", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL redir_setup_pc got=%h want=20", pc_out); end
    step(1, 32'h100, 0, 1);
    checks++; if ({ifid_valid, imem_addr, ifid_pc} !== {1'b0, 32'h100, 32'h1C}) begin
      errors++; $display("FAIL redir_ack got=%b/%h/%h want=0/00000100/0000001c", ifid_valid, imem_addr, ifid_pc);
    end
    step(0, 0, 0, 1);
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL redir_first got=%b/%h want=1/00000100", ifid_valid, ifid_pc); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1);
    step(1, 32'h200, 0, 0);
    checks++; if ({imem_req, ifid_valid, imem_addr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL disc_enter got=%b%b/%h want=10/00000040", imem_req, ifid_valid, imem_addr); end
    step(1, 32'h300, 0, 0);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL disc_retarget got=%b/%h want=1/00000040", imem_req, imem_addr); end
    step(0, 0, 0, 0);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL disc_wait got=%b/%h want=1/00000040", imem_req, imem_addr); end
    step(0, 0, 0, 1);
    checks++; if ({ifid_valid, imem_addr} !== {1'b0, 32'h300}) begin errors++; $display("FAIL disc_ack got=%b/%h want=0/00000300", ifid_valid, imem_addr); end
    step(0, 0, 0, 1);
    checks++; if ({ifid_valid, ifid_pc} !== {1'b1, 32'h300}) begin errors++; $display("FAIL disc_first got=%b/%h want=1/00000300", ifid_valid, ifid_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++; if ({pc_out, ifid_valid, imem_req} !== {RST_PC, 2'b00}) begin errors++; $display("FAIL midreset_async got=%h/%b%b want=%h/00", pc_out, ifid_valid, imem_req, RST_PC); end
    imem_ack = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0, 1);
    checks++; if ({pc_out, ifid_valid, imem_req} !== {RST_PC, 2'b01}) begin errors++; $display("FAIL midreset_stray_ack got=%h/%b%b want=%h/01", pc_out, ifid_valid, imem_req, RST_PC); end
  endtask

  task automatic test_random();
    logic [129:0] got, exp;
    bit rd, st, ak;
    logic [31:0] tgt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
      end
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ak  = ($urandom_range(0, 9) < 6);
      tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
      step(rd, tgt, st, ak);
      got = {pc_out, imem_addr, imem_req, ifid_valid, ifid_pc, ifid_instr};
      exp = {m_pc, m_pc, m_started && !m_hold, m_vld, m_ipc, m_instr};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random_%0d got=%h want=%h", i, got, exp); end
`ifdef FETCH_PERF_EN
      checks++;
      if ({fetch_cnt, bubble_cnt} !== {m_fetch, m_bubble}) begin
        errors++; $display("FAIL random_cnt_%0d got=%0d/%0d want=%0d/%0d", i, fetch_cnt, bubble_cnt, m_fetch, m_bubble);
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    checks++; if ({fetch_cnt, bubble_cnt} !== {32'd10, 32'd2}) begin errors++; $display("FAIL perf_counts got=%0d/%0d want=10/2", fetch_cnt, bubble_cnt); end
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    m_fetch = 32'hFFFF_FFFF;
    #1 release dut.r_fetch_cnt;
    step(0, 0, 0, 1);
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_wrap got=%h want=00000000", fetch_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_stall_skid();
    test_redirect_ack();
    test_redirect_discard();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
